// File: rtl/rv_regfile_mp.sv
// Parametrised register file: NREAD registered read ports, one writeback port,
// write-first forwarding, stall-coherent operand holds, late bypass and a hardware clear sequencer.
module rv_regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  d_stall_i,
    input  logic [NREAD*AW-1:0]   rf_rs_i,
    input  logic [NREAD*AW-1:0]   d_rs_i,
    output logic [NREAD*XLEN-1:0] x_rs_value_o,
    input  logic [AW-1:0]         w_rd_i,
    input  logic [XLEN-1:0]       w_rd_value_i,
    input  logic                  w_rd_store_i,
    input  logic                  w_bypass_rd_write_i,
    input  logic [XLEN-1:0]       w_bypass_rd_value_i,
    output logic                  init_busy_o
);

    localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);

    // ST_CLEAR: writing zero to register r_clr_cnt; ST_RUN: normal operation
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;

    logic [XLEN-1:0] r_mem       [NREAD][NREGS];
    logic [XLEN-1:0] r_hold_val  [NREAD];
    logic [AW-1:0]   r_hold_addr [NREAD];

    logic [AW-1:0]   w_rf_rs [NREAD];
    logic [AW-1:0]   w_d_rs  [NREAD];
    logic            w_byp   [NREAD];

    logic w_run;
    logic w_clr_we;
    logic w_wr_en;
    logic w_cap_en;

    assign w_run       = (r_state == ST_RUN);
    assign w_clr_we    = (r_state == ST_CLEAR) && !rst_i;
    assign w_wr_en     = w_run && !rst_i && w_rd_store_i && (w_rd_i != '0);
    assign w_cap_en    = w_run && !d_stall_i;
    assign init_busy_o = (r_state == ST_CLEAR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == CNT_LAST) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + CNT_ONE;
        end
    end

    // One 1R1W copy per read port; all copies see the same write.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NREAD; p++) begin
            if (w_clr_we)
                r_mem[p][r_clr_cnt] <= '0;
            else if (w_wr_en)
                r_mem[p][w_rd_i] <= w_rd_value_i;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NREAD; p++) begin
            if (rst_i || !w_run) begin
                r_hold_val[p]  <= '0;
                r_hold_addr[p] <= '0;
            end else if (w_cap_en) begin
                r_hold_addr[p] <= w_rf_rs[p];
                if (w_rf_rs[p] == '0)
                    r_hold_val[p] <= '0;
                else if (w_wr_en && (w_rd_i == w_rf_rs[p]))
                    r_hold_val[p] <= w_rd_value_i;
                else
                    r_hold_val[p] <= r_mem[p][w_rf_rs[p]];
            end else if (w_wr_en && (w_rd_i == r_hold_addr[p])) begin
                // keeps a stalled operand coherent with writeback
                r_hold_val[p] <= w_rd_value_i;
            end
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_port
        assign w_rf_rs[g] = rf_rs_i[g*AW +: AW];
        assign w_d_rs[g]  = d_rs_i[g*AW +: AW];
        assign w_byp[g]   = w_run && w_bypass_rd_write_i && (w_rd_i == w_d_rs[g]) && (w_rd_i != '0);
        assign x_rs_value_o[g*XLEN +: XLEN] = w_byp[g] ? w_bypass_rd_value_i : r_hold_val[g];
    end

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Scoreboard bench for rv_regfile_mp with three read ports: stimulus queues expected
// values, a negedge monitor pops and compares them against the DUT outputs.
module tb_rv_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 3;
    localparam int AW    = 5;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  d_stall_i;
    logic [NREAD*AW-1:0]   rf_rs_i;
    logic [NREAD*AW-1:0]   d_rs_i;
    logic [NREAD*XLEN-1:0] x_rs_value_o;
    logic [AW-1:0]         w_rd_i;
    logic [XLEN-1:0]       w_rd_value_i;
    logic                  w_rd_store_i;
    logic                  w_bypass_rd_write_i;
    logic [XLEN-1:0]       w_bypass_rd_value_i;
    logic                  init_busy_o;

    rv_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .d_stall_i           (d_stall_i),
        .rf_rs_i             (rf_rs_i),
        .d_rs_i              (d_rs_i),
        .x_rs_value_o        (x_rs_value_o),
        .w_rd_i              (w_rd_i),
        .w_rd_value_i        (w_rd_value_i),
        .w_rd_store_i        (w_rd_store_i),
        .w_bypass_rd_write_i (w_bypass_rd_write_i),
        .w_bypass_rd_value_i (w_bypass_rd_value_i),
        .init_busy_o         (init_busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        is_busy;
        logic [1:0]  port;
        logic [31:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    always @(negedge clk_i) begin
        exp_t        e;
        string       nm;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = e.is_busy ? {31'b0, init_busy_o} : x_rs_value_o[int'(e.port)*XLEN +: XLEN];
            n_checks++;
            if (act !== e.val) begin
                n_errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic exp_port(input int p, input logic [31:0] v, input string nm);
        exp_t e;
        e.is_busy = 1'b0;
        e.port    = 2'(p);
        e.val     = v;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic exp_busy(input logic b, input string nm);
        exp_t e;
        e.is_busy = 1'b1;
        e.port    = 2'd0;
        e.val     = {31'b0, b};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic set_rs(input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0);
        rf_rs_i = {a2, a1, a0};
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] v);
        w_rd_i       = rd;
        w_rd_value_i = v;
        w_rd_store_i = 1'b1;
        tick();
        w_rd_store_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        d_stall_i = 1'b0;
        rf_rs_i = '0;
        d_rs_i = '0;
        w_rd_i = '0;
        w_rd_value_i = '0;
        w_rd_store_i = 1'b0;
        w_bypass_rd_write_i = 1'b0;
        w_bypass_rd_value_i = '0;

        repeat (3) tick();
        exp_busy(1'b1, "reset_busy");
        for (int p = 0; p < NREAD; p++) exp_port(p, 32'h0, $sformatf("reset_val_p%0d", p));

        // release; writeback and stall during clear must be ignored
        rst_i = 1'b0;
        w_rd_i = 5'd5;
        w_rd_value_i = 32'h5555_5555;
        w_rd_store_i = 1'b1;
        d_stall_i = 1'b1;
        for (int k = 1; k <= NREGS; k++) begin
            tick();
            if (k == NREGS - 1) begin
                w_rd_store_i = 1'b0;
                d_stall_i = 1'b0;
            end
            exp_busy(k < NREGS, $sformatf("clear_busy_e%0d", k));
        end

        for (int r = 0; r < NREGS; r += 3) begin
            set_rs(5'(r + 2), 5'(r + 1), 5'(r));
            tick();
            for (int p = 0; p < NREAD; p++) exp_port(p, 32'h0, $sformatf("cleared_x%0d", (r + p) % NREGS));
        end

        // write then read, and x0 writes dropped
        set_rs(5'd0, 5'd0, 5'd0);
        write_reg(5'd5, 32'hDEAD_BEEF);
        set_rs(5'd0, 5'd0, 5'd5);
        tick();
        exp_port(0, 32'hDEAD_BEEF, "read_x5");
        write_reg(5'd0, 32'h0000_1234);
        set_rs(5'd0, 5'd5, 5'd0);
        tick();
        exp_port(0, 32'h0, "read_x0");
        exp_port(1, 32'hDEAD_BEEF, "read_x5_p1");

        // write-first on two ports in the same edge
        set_rs(5'd0, 5'd7, 5'd7);
        write_reg(5'd7, 32'hA5A5_A5A5);
        exp_port(0, 32'hA5A5_A5A5, "wfirst_p0");
        exp_port(1, 32'hA5A5_A5A5, "wfirst_p1");
        exp_port(2, 32'h0, "wfirst_p2");

        set_rs(5'd0, 5'd0, 5'd0);
        write_reg(5'd1, 32'h11);
        write_reg(5'd2, 32'h22);
        write_reg(5'd3, 32'h33);
        set_rs(5'd3, 5'd2, 5'd1);
        tick();
        exp_port(0, 32'h11, "multi_p0");
        exp_port(1, 32'h22, "multi_p1");
        exp_port(2, 32'h33, "multi_p2");

        // stall coherency
        set_rs(5'd0, 5'd0, 5'd0);
        write_reg(5'd9, 32'h1);
        set_rs(5'd0, 5'd0, 5'd9);
        tick();
        exp_port(0, 32'h1, "stall_cap_x9");
        d_stall_i = 1'b1;
        set_rs(5'd0, 5'd0, 5'd3);
        write_reg(5'd9, 32'h2);
        exp_port(0, 32'h2, "stall_update_x9");
        write_reg(5'd10, 32'h77);
        exp_port(0, 32'h2, "stall_unrelated");
        d_stall_i = 1'b0;
        set_rs(5'd0, 5'd0, 5'd10);
        tick();
        exp_port(0, 32'h77, "after_stall_x10");

        // late bypass
        set_rs(5'd3, 5'd2, 5'd1);
        tick();
        w_bypass_rd_write_i = 1'b1;
        w_bypass_rd_value_i = 32'hCAFE_0000;
        w_rd_i = 5'd4;
        d_rs_i = {5'd2, 5'd4, 5'd4};
        exp_port(0, 32'hCAFE_0000, "bypass_p0");
        exp_port(1, 32'hCAFE_0000, "bypass_p1");
        exp_port(2, 32'h33, "bypass_nomatch_p2");
        tick();
        w_rd_i = 5'd0;
        d_rs_i = '0;
        exp_port(0, 32'h11, "bypass_x0_p0");
        exp_port(1, 32'h22, "bypass_x0_p1");
        exp_port(2, 32'h33, "bypass_x0_p2");
        tick();
        w_bypass_rd_write_i = 1'b0;

        // reset mid-clear restarts the full sequence
        rst_i = 1'b1;
        tick();
        exp_busy(1'b1, "rst2_busy");
        exp_port(0, 32'h0, "rst2_val_p0");
        rst_i = 1'b0;
        repeat (20) tick();
        exp_busy(1'b1, "midclear_busy");
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        set_rs(5'd7, 5'd9, 5'd5);
        for (int k = 1; k <= NREGS; k++) begin
            tick();
            exp_busy(k < NREGS, $sformatf("reclear_busy_e%0d", k));
        end
        tick();
        exp_port(0, 32'h0, "reclear_x5");
        exp_port(1, 32'h0, "reclear_x9");
        exp_port(2, 32'h0, "reclear_x7");

        tick();
        @(negedge clk_i);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
